gshare_btb_predictor: RTL and testbench

Parametrised successor to the fetch-stage branch predictor. It combines a direct-mapped, tagged branch target buffer (BTB) with a gshare pattern history table (PHT) of saturating counters, indexed by PC XOR global history. Fetch looks it up combinationally each cycle. The execute/resolve stage updates it one branch or jump per cycle.

---
 rtl/gshare_btb_predictor.sv | 142 ++++++++++++++
 tb/tb_gshare_btb_predictor.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_btb_predictor.sv
// Fetch-stage branch predictor: direct-mapped tagged BTB plus a gshare PHT of
// saturating counters indexed by pc XOR global history. Lookup is combinational.
module gshare_btb_predictor #(
   parameter int ADDR_W    = 64,
   parameter int ENTRIES   = 64,
   parameter int HIST_BITS = 6,
   parameter int CTR_BITS  = 2
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic [ADDR_W-1:0]    pc,
   output logic                 pred_taken,
   output logic [ADDR_W-1:0]    target,
   output logic                 btb_hit,
   input  logic                 upd_valid,
   input  logic [ADDR_W-1:0]    upd_pc,
   input  logic                 upd_branch,
   input  logic                 upd_taken,
   input  logic [ADDR_W-1:0]    upd_target,
   output logic [HIST_BITS-1:0] hist
);

   localparam int IDX   = $clog2(ENTRIES);
   localparam int TAG_W = ADDR_W - IDX - 2;

   localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;
   localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1'b1);
   localparam logic [ADDR_W-1:0]   PC_STEP  = ADDR_W'(3'b100);

   // Saturating up/down step of one PHT counter.
   function automatic logic [CTR_BITS-1:0] ctr_step(
      input logic [CTR_BITS-1:0] cur,
      input logic                taken
   );
      logic [CTR_BITS-1:0] nxt;
      nxt = cur;
      if (taken) begin
         if (cur != CTR_MAX) begin
            nxt = cur + CTR_ONE;
         end else begin
            nxt = cur;
         end
      end else begin
         if (cur != '0) begin
            nxt = cur - CTR_ONE;
         end else begin
            nxt = cur;
         end
      end
      return nxt;
   endfunction

   logic                 valid_r [ENTRIES];
   logic                 jmp_r   [ENTRIES];
   logic [TAG_W-1:0]     tag_r   [ENTRIES];
   logic [ADDR_W-1:0]    tgt_r   [ENTRIES];
   logic [CTR_BITS-1:0]  ctr_r   [ENTRIES];
   logic [HIST_BITS-1:0] hist_r;

   logic [IDX-1:0]       bidx_s;
   logic [IDX-1:0]       pidx_s;
   logic [TAG_W-1:0]     tag_s;
   logic [IDX-1:0]       upd_bidx_s;
   logic [IDX-1:0]       upd_pidx_s;
   logic [TAG_W-1:0]     upd_tag_s;
   logic                 btb_hit_s;
   logic                 pred_taken_s;
   logic [ADDR_W-1:0]    target_s;
   logic                 btb_write_s;
   logic [HIST_BITS:0]   hist_shift_s;
   logic                 unused_s;

   // Instructions are word aligned, so the two low PC bits carry no information.
   assign unused_s = ^{pc[1:0], upd_pc[1:0]};

   // Lookup and update index/tag derivation; both use the committed history.
   always_comb begin
      bidx_s       = pc[IDX+1:2];
      tag_s        = pc[ADDR_W-1:IDX+2];
      pidx_s       = bidx_s ^ IDX'(hist_r);
      upd_bidx_s   = upd_pc[IDX+1:2];
      upd_tag_s    = upd_pc[ADDR_W-1:IDX+2];
      upd_pidx_s   = upd_bidx_s ^ IDX'(hist_r);
      hist_shift_s = {hist_r, upd_taken};
      btb_write_s  = upd_valid && (!upd_branch || upd_taken);
   end

   // Combinational prediction from current state; no bypass from a same-cycle update.
   always_comb begin
      btb_hit_s    = valid_r[bidx_s] && (tag_r[bidx_s] == tag_s);
      pred_taken_s = btb_hit_s && (jmp_r[bidx_s] || ctr_r[pidx_s][CTR_BITS-1]);
      if (pred_taken_s) begin
         target_s = tgt_r[bidx_s];
      end else begin
         target_s = pc + PC_STEP;
      end
   end

   assign btb_hit    = btb_hit_s;
   assign pred_taken = pred_taken_s;
   assign target     = target_s;
   assign hist       = hist_r;

   // BTB: written by jumps and taken branches; a different tag simply overwrites.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_r[i] <= 1'b0;
            jmp_r[i]   <= 1'b0;
            tag_r[i]   <= '0;
            tgt_r[i]   <= '0;
         end
      end else if (btb_write_s) begin
         valid_r[upd_bidx_s] <= 1'b1;
         jmp_r[upd_bidx_s]   <= !upd_branch;
         tag_r[upd_bidx_s]   <= upd_tag_s;
         tgt_r[upd_bidx_s]   <= upd_target;
      end
   end

   // PHT: every resolved conditional branch trains its counter, hit or miss.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_r[i] <= CTR_INIT;
         end
      end else if (upd_valid && upd_branch) begin
         ctr_r[upd_pidx_s] <= ctr_step(ctr_r[upd_pidx_s], upd_taken);
      end
   end

   // Non-speculative global history: shifted only by resolved conditional branches.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hist_r <= '0;
      end else if (upd_valid && upd_branch) begin
         hist_r <= hist_shift_s[HIST_BITS-1:0];
      end
   end

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Directed bench for gshare_btb_predictor: a 16-entry/2-bit instance and a
// 64-entry/3-bit instance, with hand-derived expected predictions.
module tb_gshare_btb_predictor;

   logic        clk;
   logic        nrst;

   logic [63:0] pc_a;
   logic        pred_a;
   logic [63:0] tgt_a;
   logic        hit_a;
   logic        ua_valid;
   logic [63:0] ua_pc;
   logic        ua_br;
   logic        ua_tk;
   logic [63:0] ua_tgt;
   logic [3:0]  hist_a;

   logic [63:0] pc_b;
   logic        pred_b;
   logic [63:0] tgt_b;
   logic        hit_b;
   logic        ub_valid;
   logic [63:0] ub_pc;
   logic        ub_br;
   logic        ub_tk;
   logic [63:0] ub_tgt;
   logic [5:0]  hist_b;

   int n_checks = 0;
   int n_pass   = 0;

   gshare_btb_predictor #(
      .ADDR_W(64), .ENTRIES(16), .HIST_BITS(4), .CTR_BITS(2)
   ) dut_a (
      .CLK(clk), .nRST(nrst), .pc(pc_a),
      .pred_taken(pred_a), .target(tgt_a), .btb_hit(hit_a),
      .upd_valid(ua_valid), .upd_pc(ua_pc), .upd_branch(ua_br),
      .upd_taken(ua_tk), .upd_target(ua_tgt), .hist(hist_a)
   );

   gshare_btb_predictor #(
      .ADDR_W(64), .ENTRIES(64), .HIST_BITS(6), .CTR_BITS(3)
   ) dut_b (
      .CLK(clk), .nRST(nrst), .pc(pc_b),
      .pred_taken(pred_b), .target(tgt_b), .btb_hit(hit_b),
      .upd_valid(ub_valid), .upd_pc(ub_pc), .upd_branch(ub_br),
      .upd_taken(ub_tk), .upd_target(ub_tgt), .hist(hist_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic upd_a(input logic [63:0] p, input logic br, input logic tk, input logic [63:0] t);
      ua_pc = p; ua_br = br; ua_tk = tk; ua_tgt = t; ua_valid = 1'b1;
      @(posedge clk); #1;
      ua_valid = 1'b0;
   endtask

   task automatic upd_b(input logic [63:0] p, input logic br, input logic tk, input logic [63:0] t);
      ub_pc = p; ub_br = br; ub_tk = tk; ub_tgt = t; ub_valid = 1'b1;
      @(posedge clk); #1;
      ub_valid = 1'b0;
   endtask

   task automatic look_a(input logic [63:0] p);
      pc_a = p;
      #1;
   endtask

   task automatic look_b(input logic [63:0] p);
      pc_b = p;
      #1;
   endtask

   initial begin
      nrst = 1'b0;
      pc_a = 64'h1000; ua_valid = 1'b0; ua_pc = 64'h0; ua_br = 1'b0; ua_tk = 1'b0; ua_tgt = 64'h0;
      pc_b = 64'h0;    ub_valid = 1'b0; ub_pc = 64'h0; ub_br = 1'b0; ub_tk = 1'b0; ub_tgt = 64'h0;
      #12;
      check_val("rst_a_hit",  hit_a,  1'b0);
      check_val("rst_a_pred", pred_a, 1'b0);
      check_val("rst_a_tgt",  tgt_a,  64'h1004);
      check_val("rst_a_hist", hist_a, 4'h0);
      check_val("rst_b_hit",  hit_b,  1'b0);
      check_val("rst_b_tgt",  tgt_b,  64'h4);
      check_val("rst_b_hist", hist_b, 6'h0);
      @(posedge clk); #1;
      nrst = 1'b1;

      // Same-cycle lookup of the first taken update sees pre-update state.
      pc_a = 64'h1000;
      ua_pc = 64'h1000; ua_br = 1'b1; ua_tk = 1'b1; ua_tgt = 64'h2000; ua_valid = 1'b1;
      #1;
      check_val("same_cyc_pred", pred_a, 1'b0);
      check_val("same_cyc_tgt",  tgt_a,  64'h1004);
      @(posedge clk); #1;
      ua_valid = 1'b0;
      look_a(64'h1000);
      check_val("first_upd_hit",  hit_a,  1'b1);
      check_val("first_upd_pred", pred_a, 1'b0);   // hist=0001 moves lookup to pidx 1 (01)
      check_val("first_upd_hist", hist_a, 4'h1);

      // Three more taken updates fill history with ones; pidx 15 still untrained.
      for (int i = 0; i < 3; i++) upd_a(64'h1000, 1'b1, 1'b1, 64'h2000);
      check_val("hist_ones", hist_a, 4'hF);
      look_a(64'h1000);
      check_val("pidx15_untrained", pred_a, 1'b0);

      upd_a(64'h1000, 1'b1, 1'b1, 64'h2000);        // ctr15 01->10
      look_a(64'h1000);
      check_val("ctr10_pred", pred_a, 1'b1);
      check_val("ctr10_tgt",  tgt_a,  64'h2000);
      for (int i = 0; i < 3; i++) upd_a(64'h1000, 1'b1, 1'b1, 64'h2000);  // 11, 11, 11
      upd_a(64'h1000, 1'b1, 1'b0, 64'h2000);        // ctr15 11->10, hist 1110
      check_val("nt_hist", hist_a, 4'hE);
      for (int i = 0; i < 4; i++) upd_a(64'h1000, 1'b1, 1'b1, 64'h2000);  // restore hist 1111
      check_val("restore_hist", hist_a, 4'hF);
      look_a(64'h1000);
      check_val("sat_one_nt_pred", pred_a, 1'b1);
      upd_a(64'h1000, 1'b1, 1'b0, 64'h2000);        // ctr15 10->01
      for (int i = 0; i < 4; i++) upd_a(64'h1000, 1'b1, 1'b1, 64'h2000);
      look_a(64'h1000);
      check_val("two_nt_pred", pred_a, 1'b0);
      check_val("two_nt_tgt",  tgt_a,  64'h1004);
      check_val("two_nt_hit",  hit_a,  1'b1);

      // Mid-simulation reset, with an update held across reset release.
      nrst = 1'b0;
      look_a(64'h1000);
      check_val("mid_rst_hit",  hit_a,  1'b0);
      check_val("mid_rst_pred", pred_a, 1'b0);
      check_val("mid_rst_tgt",  tgt_a,  64'h1004);
      check_val("mid_rst_hist", hist_a, 4'h0);
      ua_pc = 64'h1010; ua_br = 1'b1; ua_tk = 1'b1; ua_tgt = 64'h3000; ua_valid = 1'b1;
      @(posedge clk); #1;
      check_val("in_rst_hist", hist_a, 4'h0);
      #2;
      nrst = 1'b1;
      @(posedge clk); #1;
      ua_valid = 1'b0;
      look_a(64'h1010);
      check_val("alias_hit",  hit_a,  1'b1);
      check_val("alias_pred", pred_a, 1'b0);        // reads pidx 5, still 01
      check_val("alias_tgt",  tgt_a,  64'h1014);
      check_val("alias_hist", hist_a, 4'h1);

      // Jump at 0x40: same-cycle miss, taken afterwards, history untouched.
      pc_a = 64'h40;
      ua_pc = 64'h40; ua_br = 1'b0; ua_tk = 1'b1; ua_tgt = 64'h80; ua_valid = 1'b1;
      #1;
      check_val("jmp_pre_hit", hit_a, 1'b0);
      check_val("jmp_pre_tgt", tgt_a, 64'h44);
      @(posedge clk); #1;
      ua_valid = 1'b0;
      look_a(64'h40);
      check_val("jmp_hit",  hit_a,  1'b1);
      check_val("jmp_pred", pred_a, 1'b1);
      check_val("jmp_tgt",  tgt_a,  64'h80);
      check_val("jmp_hist", hist_a, 4'h1);

      // Taken branch at 0x80 shares index 0 with a different tag.
      upd_a(64'h80, 1'b1, 1'b1, 64'h100);           // hist -> 0011
      look_a(64'h40);
      check_val("conflict_hit", hit_a, 1'b0);
      check_val("conflict_tgt", tgt_a, 64'h44);
      look_a(64'h80);
      check_val("br80_hit",  hit_a,  1'b1);
      check_val("br80_pred", pred_a, 1'b0);         // pidx 3 is 01, jmp cleared
      check_val("br80_hist", hist_a, 4'h3);

      upd_a(64'h80, 1'b1, 1'b0, 64'h100);           // not-taken hit keeps entry
      look_a(64'h80);
      check_val("nt_hit_kept", hit_a, 1'b1);
      check_val("nt_hit_tgt",  tgt_a, 64'h84);
      check_val("nt_hit_hist", hist_a, 4'h6);
      upd_a(64'h2000, 1'b1, 1'b0, 64'h900);         // not-taken miss leaves BTB alone
      look_a(64'h80);
      check_val("nt_miss_kept", hit_a, 1'b1);
      look_a(64'h2000);
      check_val("nt_miss_hit",  hit_a, 1'b0);
      check_val("nt_miss_hist", hist_a, 4'hC);

      // Idle cycles with garbage update fields and upd_valid low.
      ua_pc = 64'h80; ua_br = 1'b1; ua_tk = 1'b1; ua_tgt = 64'h500; ua_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      look_a(64'h80);
      check_val("idle_hist", hist_a, 4'hC);
      check_val("idle_tgt",  tgt_a,  64'h84);

      look_a(64'hFFFF_FFFF_FFFF_FFFC);
      check_val("wrap_hit", hit_a, 1'b0);
      check_val("wrap_tgt", tgt_a, 64'h0);

      // Wide instance: 3-bit counters start at 011.
      upd_b(64'h0, 1'b1, 1'b1, 64'h800);
      look_b(64'h0);
      check_val("b_hit",       hit_b,  1'b1);
      check_val("b_init_pred", pred_b, 1'b0);
      check_val("b_init_tgt",  tgt_b,  64'h4);
      for (int i = 0; i < 5; i++) upd_b(64'h0, 1'b1, 1'b1, 64'h800);
      check_val("b_hist_ones", hist_b, 6'h3F);
      look_b(64'h0);
      check_val("b_p63_init", pred_b, 1'b0);
      upd_b(64'h0, 1'b1, 1'b1, 64'h800);            // ctr63 011->100
      look_b(64'h0);
      check_val("b_msb_pred", pred_b, 1'b1);
      check_val("b_msb_tgt",  tgt_b,  64'h800);
      for (int i = 0; i < 4; i++) upd_b(64'h0, 1'b1, 1'b1, 64'h800);  // 101,110,111,111
      look_b(64'h0);
      check_val("b_sat_pred", pred_b, 1'b1);
      upd_b(64'h0, 1'b1, 1'b0, 64'h800);            // ctr63 111->110, hist 111110
      check_val("b_nt_hist", hist_b, 6'h3E);
      look_b(64'h0);
      check_val("b_p62_pred", pred_b, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
